// File: rtl/queue_server.sv
// Consumer end of the ticket queue: fetches the head entry, counts its service time down on tick, pulses done.
// Optional build macro SERVER_PAUSE_EN adds a `pause` input that freezes SERVE and holds IDLE.
module queue_server #(
  parameter int DT_SZ = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef SERVER_PAUSE_EN
  input  logic             pause,
`endif
  input  logic             empty,
  input  logic [DT_SZ-1:0] qn,
  input  logic [DT_SZ-1:0] qt,
  input  logic             tick,
  output logic             re,
  output logic             busy,
  output logic [DT_SZ-1:0] cur_num,
  output logic [DT_SZ-1:0] remain,
  output logic             done,
  output logic [CNT_W-1:0] served_cnt
);

  typedef enum logic [1:0] {IDLE, FETCH, SERVE, DONE} state_t;

  state_t state_reg;
  logic   freeze;

`ifdef SERVER_PAUSE_EN
  assign freeze = pause;
`else
  assign freeze = 1'b0;
`endif

  // Outputs are registered alongside the state so each reflects the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      re         <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      cur_num    <= '0;
      remain     <= '0;
      served_cnt <= '0;
    end else begin
      re   <= 1'b0;
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (!empty && !freeze) begin
            state_reg <= FETCH;
            re        <= 1'b1;
            busy      <= 1'b1;
          end
        end
        FETCH: begin
          cur_num <= qn;
          remain  <= qt;
          if (qt == '0) begin
            state_reg <= DONE;
            done      <= 1'b1;
          end else begin
            state_reg <= SERVE;
          end
        end
        SERVE: begin
          if (tick && !freeze) begin
            remain <= remain - DT_SZ'(1);
            if (remain == DT_SZ'(1)) begin
              state_reg <= DONE;
              done      <= 1'b1;
            end
          end
        end
        DONE: begin
          served_cnt <= served_cnt + CNT_W'(1);
          busy       <= 1'b0;
          state_reg  <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
